// File: rtl/change_pkg.sv
// change_pkg: coin and FSM state types, coin values in nickels, coin value helper
package change_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, NICKEL = 2'd1, DIME = 2'd2, QUARTER = 2'd3} coin_e;
  typedef enum logic [2:0] {IDLE, CHECK, SELECT, DISPENSE, DONE} state_e;
  localparam logic [2:0] NICKEL_VAL  = 3'd1;
  localparam logic [2:0] DIME_VAL    = 3'd2;
  localparam logic [2:0] QUARTER_VAL = 3'd5;
  function automatic logic [2:0] coin_value(coin_e c);
    return c == QUARTER ? QUARTER_VAL : c == DIME ? DIME_VAL : c == NICKEL ? NICKEL_VAL : 3'd0;
  endfunction
endpackage

// File: rtl/coin_select.sv
// coin_select: combinational greedy coin picker (largest coin that fits and is in stock)
//   i_remaining        change still owed, in nickels
//   i_inv_q/_d/_n      current inventory per coin type
//   o_pick             coin_e to dispense next, NONE if nothing fits
module coin_select import change_pkg::*; #(
  parameter int AMT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic [AMT_W-1:0] i_remaining,
  input  logic [CNT_W-1:0] i_inv_q,
  input  logic [CNT_W-1:0] i_inv_d,
  input  logic [CNT_W-1:0] i_inv_n,
  output logic [1:0]       o_pick
);
  always_comb
    o_pick = (i_remaining >= AMT_W'(QUARTER_VAL) && i_inv_q != '0) ? QUARTER :
             (i_remaining >= AMT_W'(DIME_VAL)    && i_inv_d != '0) ? DIME    :
             (i_remaining >= AMT_W'(NICKEL_VAL)  && i_inv_n != '0) ? NICKEL  : NONE;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: sequential greedy change dispenser with its own restockable coin inventory
//   req_*      purchase handshake (cost/paid in nickels), ready only in IDLE
//   restock_*  add coins of one type, any state, saturating
//   coin_*     one coin per handshake towards the ejector
//   done_*     one-cycle status pulse at the end of each transaction
//   inv_*      current inventory
//   Optional macro CHANGE_DISPENSER_STATS_EN adds stat_txn / stat_shortchange counters.
module change_dispenser import change_pkg::*; #(
  parameter int AMT_W     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_COINS = 8,
  localparam int CW       = $clog2(MAX_COINS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_cost,
  input  logic [AMT_W-1:0] req_paid,
  input  logic             restock_valid,
  input  logic [1:0]       restock_type,
  input  logic [CNT_W-1:0] restock_count,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ready,
  output logic             done_valid,
  output logic             done_exact,
  output logic             done_short,
  output logic [AMT_W-1:0] done_remaining,
  output logic [CW-1:0]    done_coins,
  output logic [CNT_W-1:0] inv_q,
  output logic [CNT_W-1:0] inv_d,
  output logic [CNT_W-1:0] inv_n
`ifdef CHANGE_DISPENSER_STATS_EN
  ,
  output logic [15:0]      stat_txn,
  output logic [15:0]      stat_shortchange
`endif
);
  state_e           r_state, w_next;
  coin_e            r_coin;
  logic [AMT_W-1:0] r_cost, r_paid, r_rem;
  logic [CW-1:0]    r_count;
  logic             r_exact, r_short;
  logic [CNT_W-1:0] r_q, r_d, r_n;
  logic [1:0]       w_pick;
  logic             w_take;
  logic [CNT_W-1:0] w_add_q, w_add_d, w_add_n;

  // old >= dec always holds (a coin is only offered when in stock), so the sum never underflows
  function automatic logic [CNT_W-1:0] inv_upd(logic [CNT_W-1:0] old, logic dec, logic [CNT_W-1:0] add);
    logic [CNT_W:0] s;
    s = {1'b0, old} + {1'b0, add} - {{CNT_W{1'b0}}, dec};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  coin_select #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_sel (
    .i_remaining(r_rem),
    .i_inv_q    (r_q),
    .i_inv_d    (r_d),
    .i_inv_n    (r_n),
    .o_pick     (w_pick)
  );

  assign w_take  = r_state == DISPENSE && coin_ready;
  assign w_add_q = (restock_valid && restock_type == QUARTER) ? restock_count : '0;
  assign w_add_d = (restock_valid && restock_type == DIME)    ? restock_count : '0;
  assign w_add_n = (restock_valid && restock_type == NICKEL)  ? restock_count : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (req_valid) w_next = CHECK;
      CHECK:    w_next = r_paid > r_cost ? SELECT : DONE;
      SELECT:   w_next = (w_pick == NONE || r_count == CW'(MAX_COINS)) ? DONE : DISPENSE;
      DISPENSE: if (coin_ready) w_next = SELECT;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_coin  <= NONE;
      r_cost  <= '0;
      r_paid  <= '0;
      r_rem   <= '0;
      r_count <= '0;
      r_exact <= 1'b0;
      r_short <= 1'b0;
      r_q     <= '0;
      r_d     <= '0;
      r_n     <= '0;
    end else begin
      r_q <= inv_upd(r_q, w_take && r_coin == QUARTER, w_add_q);
      r_d <= inv_upd(r_d, w_take && r_coin == DIME, w_add_d);
      r_n <= inv_upd(r_n, w_take && r_coin == NICKEL, w_add_n);
      if (r_state == IDLE && req_valid) begin
        r_cost  <= req_cost;
        r_paid  <= req_paid;
        r_rem   <= '0;
        r_count <= '0;
        r_exact <= 1'b0;
        r_short <= 1'b0;
      end
      if (r_state == CHECK) begin
        r_exact <= r_paid == r_cost;
        r_short <= r_paid < r_cost;
        if (r_paid > r_cost) r_rem <= r_paid - r_cost;
      end
      if (r_state == SELECT && w_next == DISPENSE) r_coin <= coin_e'(w_pick);
      if (w_take) begin
        r_rem   <= r_rem - AMT_W'(coin_value(r_coin));
        r_count <= r_count + CW'(1);
      end
    end

  assign req_ready      = r_state == IDLE;
  assign coin_valid     = r_state == DISPENSE;
  assign coin_type      = coin_valid ? r_coin : NONE;
  assign done_valid     = r_state == DONE;
  assign done_exact     = done_valid && r_exact;
  assign done_short     = done_valid && r_short;
  assign done_remaining = done_valid ? r_rem : '0;
  assign done_coins     = done_valid ? r_count : '0;
  assign inv_q          = r_q;
  assign inv_d          = r_d;
  assign inv_n          = r_n;

`ifdef CHANGE_DISPENSER_STATS_EN
  logic [15:0] r_txn, r_sc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_txn <= '0;
      r_sc  <= '0;
    end else if (done_valid) begin
      r_txn <= r_txn + 16'd1;
      if (r_rem != '0) r_sc <= r_sc + 16'd1;
    end
  assign stat_txn         = r_txn;
  assign stat_shortchange = r_sc;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven transactions plus hand-written reset/stall/restock sequences
module tb_change_dispenser;
  logic       clk = 0, rst_n = 0;
  logic       req_valid = 0, req_ready;
  logic [7:0] req_cost = 0, req_paid = 0;
  logic       restock_valid = 0;
  logic [1:0] restock_type = 0;
  logic [3:0] restock_count = 0;
  logic       coin_valid, coin_ready = 0;
  logic [1:0] coin_type;
  logic       done_valid, done_exact, done_short;
  logic [7:0] done_remaining;
  logic [3:0] done_coins;
  logic [3:0] inv_q, inv_d, inv_n;
  int total = 0, bad = 0;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cost(req_cost), .req_paid(req_paid),
    .restock_valid(restock_valid), .restock_type(restock_type), .restock_count(restock_count),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
    .done_valid(done_valid), .done_exact(done_exact), .done_short(done_short),
    .done_remaining(done_remaining), .done_coins(done_coins),
    .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rq, rd, rn;
    logic [7:0] cost, paid;
    int sidx, slen;
    logic ex, sh;
    logic [7:0] rem;
    int coins;
    logic [15:0] seq;
    logic [3:0] q, d, n;
    int lat;
  } vec_t;
  vec_t v[8];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic restock(input logic [1:0] t, input logic [3:0] c);
    @(negedge clk);
    restock_valid = 1; restock_type = t; restock_count = c;
    @(negedge clk);
    restock_valid = 0; restock_count = 0;
  endtask

  task automatic wait_sig(input int which, input string name);
    bit hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      hit = which == 0 ? coin_valid : done_valid;
    end
    if (!hit) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_txn(input logic [7:0] cost, input logic [7:0] paid, input int sidx, input int slen,
                         output int lat, output int n, output logic [15:0] seq, output logic ex,
                         output logic sh, output logic [7:0] rem, output int coins);
    int sc = 0;
    bit fin = 0;
    logic [1:0] held = 0;
    lat = 0; n = 0; seq = 0; ex = 0; sh = 0; rem = 0; coins = 0;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1; req_cost = cost; req_paid = paid;
    for (int k = 1; k <= 300 && !fin; k++) begin
      @(negedge clk);
      req_valid = 0; coin_ready = 0;
      if (done_valid) begin
        fin = 1; lat = k; ex = done_exact; sh = done_short; rem = done_remaining; coins = int'(done_coins);
      end else if (coin_valid) begin
        if (n == sidx && sc < slen) begin
          if (sc == 0) held = coin_type;
          else chk("stall_type", coin_type, held);
          sc++;
        end else begin
          if (n < 8) seq[2*n +: 2] = coin_type;
          n++;
          coin_ready = 1;
        end
      end
    end
    if (!fin) chk("txn_timeout", 0, 1);
  endtask

  initial begin
    int lat, n, coins;
    logic [15:0] seq;
    logic ex, sh;
    logic [7:0] rem;
    v[0] = '{4'd2, 4'd1, 4'd3, 8'd10, 8'd10,  0, 0, 1'b1, 1'b0, 8'd0,   0, 16'h0000, 4'd2, 4'd1, 4'd3, 2};
    v[1] = '{4'd0, 4'd0, 4'd0, 8'd8,  8'd10,  0, 0, 1'b0, 1'b0, 8'd0,   1, 16'h0002, 4'd2, 4'd0, 4'd3, 5};
    v[2] = '{4'd0, 4'd0, 4'd0, 8'd10, 8'd5,   0, 0, 1'b0, 1'b1, 8'd0,   0, 16'h0000, 4'd2, 4'd0, 4'd3, 2};
    v[3] = '{4'd0, 4'd0, 4'd0, 8'd0,  8'd10,  0, 0, 1'b0, 1'b0, 8'd0,   2, 16'h000F, 4'd0, 4'd0, 4'd3, 0};
    v[4] = '{4'd0, 4'd1, 4'd0, 8'd0,  8'd1,   0, 0, 1'b0, 1'b0, 8'd0,   1, 16'h0001, 4'd0, 4'd1, 4'd2, 0};
    v[5] = '{4'd0, 4'd0, 4'd0, 8'd6,  8'd10,  0, 0, 1'b0, 1'b0, 8'd0,   3, 16'h0016, 4'd0, 4'd0, 4'd0, 0};
    v[6] = '{4'd0, 4'd0, 4'd0, 8'd6,  8'd10,  0, 0, 1'b0, 1'b0, 8'd4,   0, 16'h0000, 4'd0, 4'd0, 4'd0, 3};
    v[7] = '{4'd15, 4'd0, 4'd0, 8'd0, 8'd255, 3, 5, 1'b0, 1'b0, 8'd215, 8, 16'hFFFF, 4'd7, 4'd0, 4'd0, 0};
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_coin_type", coin_type, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_coins", done_coins, 0);
    chk("rst_inv", {inv_q, inv_d, inv_n}, 0);
    for (int i = 0; i < 8; i++) begin
      if (v[i].rq != 0) restock(2'd3, v[i].rq);
      if (v[i].rd != 0) restock(2'd2, v[i].rd);
      if (v[i].rn != 0) restock(2'd1, v[i].rn);
      run_txn(v[i].cost, v[i].paid, v[i].sidx, v[i].slen, lat, n, seq, ex, sh, rem, coins);
      chk($sformatf("v%0d_exact", i), ex, v[i].ex);
      chk($sformatf("v%0d_short", i), sh, v[i].sh);
      chk($sformatf("v%0d_remaining", i), rem, v[i].rem);
      chk($sformatf("v%0d_done_coins", i), coins, v[i].coins);
      chk($sformatf("v%0d_coins_seen", i), n, v[i].coins);
      chk($sformatf("v%0d_coin_seq", i), seq, v[i].seq);
      chk($sformatf("v%0d_inv_q", i), inv_q, v[i].q);
      chk($sformatf("v%0d_inv_d", i), inv_d, v[i].d);
      chk($sformatf("v%0d_inv_n", i), inv_n, v[i].n);
      if (v[i].lat != 0) chk($sformatf("v%0d_latency", i), lat, v[i].lat);
    end
    restock(2'd3, 4'd15);
    chk("sat_q_15", inv_q, 15);
    restock(2'd3, 4'd3);
    chk("sat_q_plus3", inv_q, 15);
    @(negedge clk);
    req_valid = 1; req_cost = 0; req_paid = 20;
    @(negedge clk);
    req_valid = 0;
    wait_sig(0, "rst_wait_coin");
    rst_n = 0;
    #1;
    chk("midrst_coin_valid", coin_valid, 0);
    chk("midrst_inv_q", inv_q, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_done", done_valid, 0);
    end
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_no_done", done_valid, 0);
    restock(2'd3, 4'd3);
    restock(2'd2, 4'd2);
    @(negedge clk);
    req_valid = 1; req_cost = 0; req_paid = 7;
    @(negedge clk);
    req_valid = 0;
    wait_sig(0, "same_wait_q");
    chk("same_coin_q", coin_type, 3);
    coin_ready = 1; restock_valid = 1; restock_type = 2'd3; restock_count = 4'd4;
    @(negedge clk);
    coin_ready = 0; restock_valid = 0; restock_count = 0;
    chk("same_cycle_inv_q", inv_q, 6);
    wait_sig(0, "same_wait_d");
    chk("same_coin_d", coin_type, 2);
    coin_ready = 1;
    @(negedge clk);
    coin_ready = 0;
    wait_sig(1, "same_wait_done");
    chk("same_remaining", done_remaining, 0);
    chk("same_done_coins", done_coins, 2);
    chk("same_inv_d", inv_d, 1);
    @(negedge clk);
    chk("done_pulse_clears", done_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
